lut_sweep_checker: RTL

- Parametrised, clocked successor to our two-input gate-equivalence exercises.
- Holds two N-input Boolean functions, each given as a truth-table mask: implementation A and implementation B.
- On start, sweeps every minterm and streams (minterm, A, B) out over a valid/ready handshake.
- Counts mismatches and reports the first failing minterm. Used as an on-chip exhaustive equivalence checker for small gate-level functions.

---
 rtl/lut_sweep_pkg.sv | 24 ++
 rtl/lut_sweep_checker_lut_eval.sv | 15 +
 rtl/lut_sweep_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the exhaustive LUT equivalence sweeper.
// Gray-order sweeping is enabled by defining LUT_SWEEP_GRAY_EN.
package lut_sweep_pkg;

    localparam int MAX_IN    = 8;
    localparam int IDX_MAX_W = MAX_IN + 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    function automatic int tbl_w(input int n);
        return 1 << n;
    endfunction

    function automatic logic [IDX_MAX_W-1:0] gray_of(
        input logic [IDX_MAX_W-1:0] idx
    );
        return idx ^ (idx >> 1);
    endfunction

endpackage

// File: rtl/lut_sweep_checker_lut_eval.sv
// Combinational truth-table lookup: returns tbl[vec].
// One instance per function under comparison.
module lut_eval
    import lut_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [tbl_w(N_IN)-1:0] tbl,
    input  logic [N_IN-1:0]        vec,
    output logic                   val
);

    assign val = tbl[vec];

endmodule

// File: rtl/lut_sweep_checker.sv
// Exhaustive equivalence sweeper for two N_IN-input truth tables.
// Define LUT_SWEEP_GRAY_EN to sweep minterms in Gray order.
module lut_sweep_checker
    import lut_sweep_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int CNT_W = N_IN + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [tbl_w(N_IN)-1:0] lut_a,
    input  logic [tbl_w(N_IN)-1:0] lut_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_IN-1:0]        out_vec,
    output logic                   out_a,
    output logic                   out_b,
    output logic                   out_diff,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic [N_IN-1:0]        first_mm,
    output logic                   mm_seen
);

    localparam int TBL_W = tbl_w(N_IN);
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TBL_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TBL_W-1:0]  tbl_a;
    logic [TBL_W-1:0]  tbl_b;
    logic [N_IN:0]     idx;
    logic [N_IN-1:0]   ord;
    logic              a_val;
    logic              b_val;
    logic              xfer;
    logic              last;

`ifdef LUT_SWEEP_GRAY_EN
    assign ord = N_IN'(gray_of(IDX_MAX_W'(idx)));
`else
    assign ord = idx[N_IN-1:0];
`endif

    lut_eval #(.N_IN(N_IN)) u_eval_a (
        .tbl (tbl_a),
        .vec (ord),
        .val (a_val)
    );

    lut_eval #(.N_IN(N_IN)) u_eval_b (
        .tbl (tbl_b),
        .vec (ord),
        .val (b_val)
    );

    assign xfer = out_valid & out_ready;
    assign last = (idx == LAST_IDX);

    // Beat fields read as zero whenever no beat is on offer.
    assign out_vec  = out_valid ? ord : '0;
    assign out_a    = out_valid & a_val;
    assign out_b    = out_valid & b_val;
    assign out_diff = out_a ^ out_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (xfer && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE:  ;
            SWEEP: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_a        <= '0;
            tbl_b        <= '0;
            idx          <= '0;
            mismatch_cnt <= '0;
            first_mm     <= '0;
            mm_seen      <= 1'b0;
        end else if (state == IDLE && start) begin
            tbl_a        <= lut_a;
            tbl_b        <= lut_b;
            idx          <= '0;
            mismatch_cnt <= '0;
            first_mm     <= '0;
            mm_seen      <= 1'b0;
        end else if (state == SWEEP && xfer) begin
            if (out_diff) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                if (!mm_seen) begin
                    first_mm <= ord;
                    mm_seen  <= 1'b1;
                end
            end
            if (!last) begin
                idx <= idx + (N_IN + 1)'(1);
            end
        end
    end

endmodule
